// File: rtl/tcm_sram_responder_pkg.sv
// Shared types and width defaults for the TCM SRAM responder and its array.
// Optional build macro: TCM_PARITY_EN (per-lane even parity storage and checking).
package tcm_sram_responder_pkg;

   localparam int unsigned ItcmRamAw = 12;
   localparam int unsigned ItcmRamDw = 32;
   localparam int unsigned DtcmRamAw = 10;
   localparam int unsigned DtcmRamDw = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StResp  = 2'd1,
      StStall = 2'd2
   } tcm_state_e;

   // Even parity: the stored bit makes the lane plus parity carry an even number of ones.
   function automatic logic lane_parity(input logic [7:0] lane);
      return ^lane;
   endfunction

endpackage

// File: rtl/tcm_sram_array.sv
// Behavioural word array with per-lane write enables and a registered read port.
// With TCM_PARITY_EN defined, one even-parity bit per lane is stored and checked on read.
module tcm_sram_array
   import tcm_sram_responder_pkg::*;
#(
   parameter int unsigned AW = DtcmRamAw,
   parameter int unsigned DW = DtcmRamDw,
   parameter int unsigned MW = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   input  logic [MW-1:0] wem,
   output logic [DW-1:0] dout
`ifdef TCM_PARITY_EN
   ,
   output logic [MW-1:0] perr
`endif
);

   localparam int unsigned Depth = 2 ** AW;

   logic [DW-1:0] mem_q [Depth];
   logic [DW-1:0] rd_data_q;

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < MW; i++) begin
            if (wem[i]) mem_q[addr][8*i +: 8] <= din[8*i +: 8];
         end
      end
   end

   // Read register only moves on a read, so it doubles as the stall hold register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (re) begin
         rd_data_q <= mem_q[addr];
      end
   end

   assign dout = rd_data_q;

`ifdef TCM_PARITY_EN
   logic [MW-1:0] par_q [Depth];
   logic [MW-1:0] rd_par_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < MW; i++) begin
            if (wem[i]) par_q[addr][i] <= lane_parity(din[8*i +: 8]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_par_q <= '0;
      end else if (re) begin
         rd_par_q <= par_q[addr];
      end
   end

   always_comb begin
      perr = '0;
      for (int unsigned i = 0; i < MW; i++) begin
         perr[i] = lane_parity(rd_data_q[8*i +: 8]) != rd_par_q[i];
      end
   end
`endif

endmodule

// File: rtl/tcm_sram_responder.sv
// TCM RAM responder: valid/ready request channel, registered read response with stall hold.
// Optional build macro: TCM_PARITY_EN adds the rsp_perr output.
module tcm_sram_responder
   import tcm_sram_responder_pkg::*;
#(
   parameter int unsigned AW = DtcmRamAw,
   parameter int unsigned DW = DtcmRamDw,
   parameter int unsigned MW = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_din,
   input  logic [MW-1:0] req_wem,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_dout,
`ifdef TCM_PARITY_EN
   output logic [MW-1:0] rsp_perr,
`endif
   output logic          busy
);

   tcm_state_e state_q, state_d;
   logic       ready_en_q;
   logic       accept;
   logic       rd_en;
   logic       wr_en;

   // ready_en_q keeps req_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;

      case (state_q)
         StIdle:  req_ready = ready_en_q;
         StResp: begin
            rsp_valid = 1'b1;
            req_ready = rsp_ready;
         end
         StStall: rsp_valid = 1'b1;
         default: req_ready = 1'b0;
      endcase

      accept = req_valid && req_ready;
      rd_en  = accept && !req_we;
      wr_en  = accept && req_we;

      case (state_q)
         StIdle: begin
            if (rd_en) state_d = StResp;
         end
         StResp: begin
            if (!rsp_ready)  state_d = StStall;
            else if (rd_en)  state_d = StResp;
            else             state_d = StIdle;
         end
         StStall: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q != StIdle);

`ifdef TCM_PARITY_EN
   logic [MW-1:0] arr_perr;
`endif

   tcm_sram_array #(
      .AW (AW),
      .DW (DW),
      .MW (MW)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .re    (rd_en),
      .addr  (req_addr),
      .din   (req_din),
      .wem   (req_wem),
`ifdef TCM_PARITY_EN
      .perr  (arr_perr),
`endif
      .dout  (rsp_dout)
   );

`ifdef TCM_PARITY_EN
   assign rsp_perr = rsp_valid ? arr_perr : '0;
`endif

endmodule

// File: tb/tb_tcm_sram_responder.sv
// Directed bench for tcm_sram_responder with a transaction-level reference model.
// Optional build macro: TCM_PARITY_EN enables the parity port and its directed check.
module tb_tcm_sram_responder;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_din = '0;
   logic [MW-1:0] req_wem = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_dout;
   logic          busy;
`ifdef TCM_PARITY_EN
   logic [MW-1:0] rsp_perr;
`endif

   tcm_sram_responder #(
      .AW (AW),
      .DW (DW),
      .MW (MW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_din   (req_din),
      .req_wem   (req_wem),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dout  (rsp_dout),
`ifdef TCM_PARITY_EN
      .rsp_perr  (rsp_perr),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one pending response at most, plus whether it has already been refused.
   logic [DW-1:0] m_mem [2**AW];
   bit            m_pend = 1'b0;
   bit            m_refused = 1'b0;
   bit            m_ready_en = 1'b0;
   logic [DW-1:0] m_data = '0;
   bit            m_rdy;
   bit            m_acc;
   bit            chk_en = 1'b0;
   logic [MW-1:0] perr_inj = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend     = 1'b0;
         m_refused  = 1'b0;
         m_ready_en = 1'b0;
         m_data     = '0;
      end else begin
         m_rdy = m_ready_en && (!m_pend || (rsp_ready && !m_refused));
         m_acc = req_valid && m_rdy;
         if (m_pend) begin
            if (rsp_ready) begin
               m_pend    = 1'b0;
               m_refused = 1'b0;
            end else begin
               m_refused = 1'b1;
            end
         end
         if (m_acc) begin
            if (req_we) begin
               for (int i = 0; i < MW; i++) begin
                  if (req_wem[i]) m_mem[req_addr][8*i +: 8] = req_din[8*i +: 8];
               end
            end else begin
               m_pend    = 1'b1;
               m_refused = 1'b0;
               m_data    = m_mem[req_addr];
            end
         end
         m_ready_en = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
         check("busy", 32'(busy), 32'(m_pend));
         check("req_ready", 32'(req_ready),
               32'(rst_n && m_ready_en && (!m_pend || (rsp_ready && !m_refused))));
         check("rsp_dout", rsp_dout, m_data);
`ifdef TCM_PARITY_EN
         check("rsp_perr", 32'(rsp_perr), 32'(m_pend ? perr_inj : 4'b0000));
`endif
      end
   end

   // Apply one cycle of inputs, then move to just after the next rising edge.
   task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m, input logic rr);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_din   = d;
      req_wem   = m;
      rsp_ready = rr;
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] pat [8];

   initial begin
      pat = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF,
              32'h1357_9BDF, 32'h2468_ACE0, 32'hF0E1_D2C3, 32'h0F1E_2D3C};

      // Reset release: ready only after the first clock.
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      rst_n  = 1'b1;
      check("ready_at_release", 32'(req_ready), 32'h0);
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);
      check("ready_after_clk", 32'(req_ready), 32'h1);
      check("reset_dout", rsp_dout, 32'h0);

      // Full-word write then read next cycle.
      step(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
      check("write_no_rsp", 32'(rsp_valid), 32'h0);
      step(1'b1, 1'b0, 8'h10, '0, 4'h0, 1'b1);
      check("raw_valid", 32'(rsp_valid), 32'h1);
      check("raw_data", rsp_dout, 32'hDEAD_BEEF);
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);

      // Single-lane write, then a wem=0 write that must change nothing.
      step(1'b1, 1'b1, 8'h10, 32'h0000_00AA, 4'b0001, 1'b1);
      step(1'b1, 1'b1, 8'h10, 32'h1234_5678, 4'b0000, 1'b1);
      step(1'b1, 1'b0, 8'h10, '0, 4'h0, 1'b1);
      check("lane0_merge", rsp_dout, 32'hDEAD_BEAA);

      // Fill 0..7, then eight back-to-back reads.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, AW'(i), pat[i], 4'hF, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, AW'(i), '0, 4'h0, 1'b1);
         check($sformatf("b2b_valid_%0d", i), 32'(rsp_valid), 32'h1);
         check($sformatf("b2b_data_%0d", i), rsp_dout, pat[i]);
      end
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);
      check("b2b_drained", 32'(rsp_valid), 32'h0);

      // Stall: response held, new reads refused.
      step(1'b1, 1'b0, 8'h10, '0, 4'h0, 1'b0);
      check("stall_first_ready", 32'(req_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 8'h00, '0, 4'h0, 1'b0);
         check($sformatf("stall_busy_%0d", i), 32'(busy), 32'h1);
         check($sformatf("stall_dout_%0d", i), rsp_dout, 32'hDEAD_BEAA);
      end
      rsp_ready = 1'b1;
      #1;
      check("stall_ready_release", 32'(req_ready), 32'h0);
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);
      check("stall_done", 32'(rsp_valid), 32'h0);

`ifdef TCM_PARITY_EN
      step(1'b1, 1'b0, 8'h10, '0, 4'h0, 1'b0);
      perr_inj = 4'b0100;
      force dut.u_array.rd_par_q[2] = 1'b0;
      #1;
      check("perr_forced", 32'(rsp_perr), 32'h4);
      @(negedge clk);
      #1;
      release dut.u_array.rd_par_q[2];
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);
      perr_inj = 4'b0000;
      step(1'b1, 1'b0, 8'h10, '0, 4'h0, 1'b1);
      check("perr_clean", 32'(rsp_perr), 32'h0);
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);
`endif

      // Reset in the middle of a response drops it at once.
      step(1'b1, 1'b0, 8'h05, '0, 4'h0, 1'b0);
      check("pre_reset_valid", 32'(rsp_valid), 32'h1);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("async_rst_valid", 32'(rsp_valid), 32'h0);
      check("async_rst_busy", 32'(busy), 32'h0);
      check("async_rst_dout", rsp_dout, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst2_ready_release", 32'(req_ready), 32'h0);
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);
      check("rst2_ready_after", 32'(req_ready), 32'h1);

      // Array survives reset.
      step(1'b1, 1'b0, 8'h03, '0, 4'h0, 1'b1);
      check("post_reset_read", rsp_dout, 32'hCCDD_EEFF);
      step(1'b0, 1'b0, 8'h00, '0, 4'h0, 1'b1);

      @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
